// File: rtl/dram_arb_pkg.sv
// Shared constants for the dram_control arbiter: FSM state encodings and requester ids.
package dram_arb_pkg;

    localparam int unsigned STATE_W = 3;

    // FSM state encodings
    localparam logic [STATE_W-1:0] SYNC      = 3'd0;
    localparam logic [STATE_W-1:0] IDLE      = 3'd1;
    localparam logic [STATE_W-1:0] START     = 3'd2;
    localparam logic [STATE_W-1:0] WAIT_BUSY = 3'd3;
    localparam logic [STATE_W-1:0] RUN       = 3'd4;
    localparam logic [STATE_W-1:0] DONE      = 3'd5;

    // Requester ids
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational winner select between two requesters.
//   req0, req1    : request levels
//   last_winner   : id of the requester served most recently
//   valid_c       : at least one request present
//   winner_c      : id of the winning requester (meaningful when valid_c)
// FIXED_PRIO != 0 makes requester 0 win ties; otherwise ties go to the
// requester that did not win last.
module dram_arb_pick
    import dram_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic valid_c,
    output logic winner_c
);

    always_comb begin
        valid_c  = req0 | req1;
        winner_c = REQ0;
        if (req0 && req1) begin
            winner_c = (FIXED_PRIO != 0) ? REQ0 : ~last_winner;
        end else if (req1) begin
            winner_c = REQ1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one dram_control sweep engine between two requesters.
//   clk, rst_n            : clock, async active-low reset
//   req0/1, rnw0/1        : request level (held until done) and direction (1=read)
//   wdat0/1               : write data from each requester
//   gnt0/1, done0/1       : registered grant and one-cycle completion pulse
//   rdy0/1                : per-word strobe (engine ready gated by grant and RUN)
//   rdat                  : engine read data broadcast
//   tmo_err               : sticky watchdog flag (cleared only by reset)
//   eng_start, eng_rnw    : engine start pulse and direction
//   eng_wdat              : write data muxed from the granted requester
//   eng_stop, eng_ready,
//   eng_rdat              : engine idle status, word strobe, read data
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned TMO_W      = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 rnw0,
    input  logic                 rnw1,
    input  logic [DATA_SIZE-1:0] wdat0,
    input  logic [DATA_SIZE-1:0] wdat1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rdy0,
    output logic                 rdy1,
    output logic                 done0,
    output logic                 done1,
    output logic [DATA_SIZE-1:0] rdat,
    output logic                 tmo_err,
    output logic                 eng_start,
    output logic                 eng_rnw,
    output logic [DATA_SIZE-1:0] eng_wdat,
    input  logic                 eng_stop,
    input  logic                 eng_ready,
    input  logic [DATA_SIZE-1:0] eng_rdat
);

    localparam logic [TMO_W-1:0] WD_MAX = '1;

    logic [STATE_W-1:0] state_q, state_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic               eng_start_q, eng_start_d;
    logic               eng_rnw_q, eng_rnw_d;
    logic               tmo_err_q, tmo_err_d;
    logic               last_winner_q, last_winner_d;
    logic               owner_q, owner_d;
    logic [TMO_W-1:0]   wd_q, wd_d;
    logic [TMO_W-1:0]   wd_inc;

    logic pick_valid_c;
    logic pick_winner_c;

    dram_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (last_winner_q),
        .valid_c     (pick_valid_c),
        .winner_c    (pick_winner_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SYNC;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_rnw_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
            last_winner_q <= REQ0;
            owner_q       <= REQ0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            eng_start_q   <= eng_start_d;
            eng_rnw_q     <= eng_rnw_d;
            tmo_err_q     <= tmo_err_d;
            last_winner_q <= last_winner_d;
            owner_q       <= owner_d;
            wd_q          <= wd_d;
        end
    end

    assign wd_inc = wd_q + TMO_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        eng_start_d   = 1'b0;
        eng_rnw_d     = eng_rnw_q;
        tmo_err_d     = tmo_err_q;
        last_winner_d = last_winner_q;
        owner_d       = owner_q;
        wd_d          = wd_q;

        case (state_q)
            // The engine is not reset with us; wait until it is idle.
            SYNC: begin
                if (eng_stop) begin
                    state_d = IDLE;
                end
            end
            // Grant and start pulse are registered on the way into START.
            IDLE: begin
                if (pick_valid_c) begin
                    state_d     = START;
                    owner_d     = pick_winner_c;
                    gnt0_d      = (pick_winner_c == REQ0);
                    gnt1_d      = (pick_winner_c == REQ1);
                    eng_rnw_d   = (pick_winner_c == REQ0) ? rnw0 : rnw1;
                    eng_start_d = 1'b1;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT_BUSY;
            end
            // Timeout fires on the cycle the incremented count would reach all-ones.
            WAIT_BUSY: begin
                if (!eng_stop) begin
                    state_d = RUN;
                end else if (wd_inc == WD_MAX) begin
                    wd_d      = wd_inc;
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                    done0_d   = gnt0_q;
                    done1_d   = gnt1_q;
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                end else begin
                    wd_d = wd_inc;
                end
            end
            RUN: begin
                if (eng_stop) begin
                    state_d = DONE;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end
            end
            DONE: begin
                last_winner_d = owner_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = SYNC;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign eng_start = eng_start_q;
    assign eng_rnw   = eng_rnw_q;
    assign tmo_err   = tmo_err_q;

    // Zero-latency word strobe and data steering from the registered grant
    assign rdy0     = eng_ready & gnt0_q & (state_q == RUN);
    assign rdy1     = eng_ready & gnt1_q & (state_q == RUN);
    assign eng_wdat = gnt0_q ? wdat0 : wdat1;
    assign rdat     = eng_rdat;

endmodule
